coproc_host_bridge: RTL and testbench

Host-side initiator for the coprocessor register file interface (one-hot writeEnable, wide writeBus, selectRead, dataOut). Accepts word-oriented write/read commands over 32-bit valid/ready channels. For writes, it assembles up to 14 words into the 448-bit writeBus and fires a single-cycle writeEnable strobe. For reads, it drives selectRead, captures dataOut and streams it back as 32-bit words.

---
 rtl/coproc_host_bridge.sv | 158 +++++++++++++++
 tb/tb_coproc_host_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/coproc_host_bridge.sv
`timescale 1ns/1ps
// Host-side initiator for the coprocessor register file: assembles 32-bit write words into the
// wide writeBus and fires a one-hot writeEnable strobe; buffers a wide dataOut read and streams
// it back as 32-bit words.
module coproc_host_bridge #(
  parameter int unsigned BUS_W  = 448,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned NREG   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [3:0]        cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [WORD_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [WORD_W-1:0] rdata,
  output logic [NREG-1:0]   writeEnable,
  output logic [BUS_W-1:0]  writeBus,
  output logic [3:0]        selectRead,
  input  logic [BUS_W-1:0]  dataOut,
  output logic              busy,
  output logic              err
);

  localparam int unsigned NWords = BUS_W / WORD_W;
  localparam logic [3:0]  MaxLen = 4'(NWords - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWcollect,
    StWcommit,
    StRlatch,
    StRsend
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       addr_q, addr_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       sel_q, sel_d;
  logic [BUS_W-1:0] wbus_q, wbus_d;
  logic [BUS_W-1:0] rbuf_q, rbuf_d;
  logic             err_q, err_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      wbus_q  <= '0;
      rbuf_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wbus_q  <= wbus_d;
      rbuf_q  <= rbuf_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: command decode, word assembly and read streaming.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wbus_d  = wbus_q;
    rbuf_d  = rbuf_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_len > MaxLen) begin
            err_d = 1'b1;
          end else if (cmd_write) begin
            addr_d  = cmd_addr;
            len_d   = cmd_len;
            wbus_d  = '0;
            cnt_d   = '0;
            state_d = StWcollect;
          end else begin
            len_d   = cmd_len;
            sel_d   = cmd_addr;
            state_d = StRlatch;
          end
        end
      end
      StWcollect: begin
        if (wdata_valid) begin
          wbus_d[WORD_W*cnt_q +: WORD_W] = wdata;
          // Final word clears the counter so it never passes the last legal index.
          if (cnt_q == len_q) begin
            cnt_d   = '0;
            state_d = StWcommit;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StWcommit: begin
        state_d = StIdle;
      end
      StRlatch: begin
        // selectRead has been stable for a full cycle, so dataOut is settled here.
        rbuf_d  = dataOut;
        cnt_d   = '0;
        state_d = StRsend;
      end
      StRsend: begin
        if (rdata_ready) begin
          if (cnt_q == len_q) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    cmd_ready   = (state_q == StIdle);
    wdata_ready = (state_q == StWcollect);
    rdata_valid = (state_q == StRsend);
    rdata       = '0;
    if (state_q == StRsend) begin
      rdata = rbuf_q[WORD_W*cnt_q +: WORD_W];
    end
    writeEnable = '0;
    if (state_q == StWcommit) begin
      writeEnable = NREG'(1) << addr_q;
    end
    writeBus   = wbus_q;
    selectRead = sel_q;
    busy       = (state_q != StIdle);
    err        = err_q;
  end

endmodule

// File: tb/tb_coproc_host_bridge.sv
`timescale 1ns/1ps
// Bench for coproc_host_bridge: a register-file model feeds dataOut and records committed writes;
// directed steps from the test plan are followed by randomized write/read pairs.
module tb_coproc_host_bridge;

  logic         clock;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [3:0]   cmd_addr;
  logic [3:0]   cmd_len;
  logic         wdata_valid;
  logic         wdata_ready;
  logic [31:0]  wdata;
  logic         rdata_valid;
  logic         rdata_ready;
  logic [31:0]  rdata;
  logic [15:0]  writeEnable;
  logic [447:0] writeBus;
  logic [3:0]   selectRead;
  logic [447:0] dataOut;
  logic         busy;
  logic         err;

  // Register file model: contents written only by the stimulus, read combinationally.
  logic [447:0] regfile [16];
  logic [31:0]  wbuf [14];
  logic [31:0]  rd_got [14];
  int n_assert = 0;
  int n_fail   = 0;

  assign dataOut = regfile[selectRead];

  coproc_host_bridge dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata       (rdata),
    .writeEnable (writeEnable),
    .writeBus    (writeBus),
    .selectRead  (selectRead),
    .dataOut     (dataOut),
    .busy        (busy),
    .err         (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [447:0] obs, input logic [447:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write transaction using words in wbuf; gap toggles wdata_valid every other cycle.
  task automatic do_write(input logic [3:0] addr, input logic [3:0] len, input bit gap);
    logic [447:0] exp;
    int i;
    int cyc;
    bit hs;
    exp = '0;
    for (int j = 0; j <= int'(len); j++) exp[32*j +: 32] = wbuf[j];
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
    chk("w_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("w_busy", busy, 1);
    i = 0;
    cyc = 0;
    while (i <= int'(len) && cyc < 100) begin
      wdata_valid = gap ? (cyc[0] == 1'b0) : 1'b1;
      wdata = wbuf[i];
      chk("w_no_strobe", writeEnable, 0);
      hs = wdata_valid && wdata_ready;
      step();
      cyc++;
      if (hs) i++;
    end
    wdata_valid = 1'b0;
    chk("w_word_count", i, int'(len) + 1);
    chk("w_strobe", writeEnable, 16'h1 << addr);
    chk("w_bus", writeBus, exp);
    chk("w_cmd_ready_n1", cmd_ready, 0);
    step();
    chk("w_strobe_off", writeEnable, 0);
    chk("w_cmd_ready_n2", cmd_ready, 1);
    chk("w_bus_hold", writeBus, exp);
    regfile[addr] = exp;
  endtask

  // Read transaction; stalls stall_n cycles on word stall_word; perturb flips the source entry
  // once streaming has begun.
  task automatic do_read(input logic [3:0] addr, input logic [3:0] len, input int stall_word,
                         input int stall_n, input bit perturb);
    logic [447:0] snap;
    snap = regfile[addr];
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
    chk("r_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("r_select", selectRead, addr);
    chk("r_valid_early", rdata_valid, 0);
    step();
    for (int i = 0; i <= int'(len); i++) begin
      if (perturb && i == 0) regfile[addr] = ~regfile[addr];
      if (i == stall_word) begin
        for (int s = 0; s < stall_n; s++) begin
          rdata_ready = 1'b0;
          chk("r_hold_valid", rdata_valid, 1);
          chk("r_hold_data", rdata, snap[32*i +: 32]);
          step();
        end
      end
      rdata_ready = 1'b1;
      chk("r_valid", rdata_valid, 1);
      chk("r_data", rdata, snap[32*i +: 32]);
      rd_got[i] = rdata;
      step();
    end
    rdata_ready = 1'b0;
    chk("r_done_ready", cmd_ready, 1);
    chk("r_done_valid", rdata_valid, 0);
    chk("r_select_hold", selectRead, addr);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int w = 0; w < 14; w++) regfile[r][32*w +: 32] = $urandom();

    // Reset state
    step();
    step();
    chk("rst_we", writeEnable, 0);
    chk("rst_bus", writeBus, 0);
    chk("rst_sel", selectRead, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);

    // Four-word write to slot 0
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
    wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    do_write(4'd0, 4'd3, 1'b0);
    chk("tp1_bus", writeBus, {320'h0, 128'h44444444_33333333_22222222_11111111});

    // Full fourteen-word write with gaps to slot 4
    for (int i = 0; i < 14; i++) wbuf[i] = i;
    do_write(4'd4, 4'd13, 1'b1);
    chk("tp2_top_word", writeBus[447:416], 32'h0000000D);

    // Read slot 2 with a stall on word 1
    regfile[2] = {320'h0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF};
    do_read(4'd2, 4'd3, 1, 3, 1'b0);
    chk("tp3_w0", rd_got[0], 32'h89ABCDEF);
    chk("tp3_w1", rd_got[1], 32'h01234567);
    chk("tp3_w2", rd_got[2], 32'hCAFEF00D);
    chk("tp3_w3", rd_got[3], 32'hDEADBEEF);

    // Illegal length
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd7; cmd_len = 4'd14;
    step();
    cmd_valid = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_ready", cmd_ready, 1);
    chk("err_we", writeEnable, 0);
    step();
    chk("err_clear", err, 0);
    chk("err_we2", writeEnable, 0);
    chk("err_busy2", busy, 0);
    wbuf[0] = 32'hA5A5A5A5; wbuf[1] = 32'h5A5A5A5A;
    do_write(4'd7, 4'd1, 1'b0);

    // Reset after two of four words
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd9; cmd_len = 4'd3;
    step();
    cmd_valid = 1'b0;
    wdata_valid = 1'b1; wdata = 32'hBBBB0001;
    step();
    wdata = 32'hBBBB0002;
    step();
    wdata_valid = 1'b0;
    reset = 1'b1;
    chk("mid_we_pre", writeEnable, 0);
    step();
    reset = 1'b0;
    chk("mid_we", writeEnable, 0);
    chk("mid_bus", writeBus, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", cmd_ready, 1);
    step();
    chk("mid_we_after", writeEnable, 0);
    chk("mid_ready_after", cmd_ready, 1);

    // Snapshot: source changes during streaming
    do_read(4'd5, 4'd13, 15, 0, 1'b1);

    // Randomized write/read pairs
    for (int t = 0; t < 20; t++) begin
      logic [3:0] a;
      logic [3:0] l;
      a = 4'($urandom_range(0, 15));
      l = 4'($urandom_range(0, 13));
      for (int i = 0; i < 14; i++) wbuf[i] = $urandom();
      do_write(a, l, 1'($urandom_range(0, 1)));
      a = 4'($urandom_range(0, 15));
      l = 4'($urandom_range(0, 13));
      do_read(a, l, $urandom_range(0, int'(l)), $urandom_range(0, 2), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
